// File: rtl/display_scan_controller.sv
// Multiplexed 8-digit seven-segment scan controller with frame-synchronous double buffering.
// Optional LEADING_ZERO_BLANK_EN blanks zero digits to the left of the first non-zero nibble.
module display_scan_controller #(
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] value_in,
   input  logic [7:0]  dp_in,
   output logic [2:0]  digit_sel,
   output logic [6:0]  seg_out,
   output logic        dp_out,
   output logic        frame_start,
   output logic        pending
);

   localparam int unsigned PW         = $clog2(REFRESH_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [2:0]    sel_q, sel_d;
   logic [31:0]   active_val_q, active_val_d;
   logic [7:0]    active_dp_q, active_dp_d;
   logic [31:0]   shadow_val_q, shadow_val_d;
   logic [7:0]    shadow_dp_q, shadow_dp_d;
   logic          pending_q, pending_d;
   logic          frame_start_q, frame_start_d;

   logic presc_term;
   logic wrap;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Next-state: scan counters plus shadow/active buffering committed on the 7->0 wrap
   always_comb begin
      presc_d       = presc_q;
      sel_d         = sel_q;
      active_val_d  = active_val_q;
      active_dp_d   = active_dp_q;
      shadow_val_d  = shadow_val_q;
      shadow_dp_d   = shadow_dp_q;
      pending_d     = pending_q;
      frame_start_d = 1'b0;

      presc_term = (presc_q == PRESC_LAST);
      wrap       = presc_term && (sel_q == 3'd7);

      if (presc_term) begin
         presc_d = '0;
         sel_d   = sel_q + 3'd1;
      end else begin
         presc_d = presc_q + PW'(1);
      end

      frame_start_d = wrap;

      if (wrap) begin
         pending_d = 1'b0;
         if (load) begin
            // Load coinciding with the commit edge bypasses the shadow; keep shadow in step
            active_val_d = value_in;
            active_dp_d  = dp_in;
            shadow_val_d = value_in;
            shadow_dp_d  = dp_in;
         end else if (pending_q) begin
            active_val_d = shadow_val_q;
            active_dp_d  = shadow_dp_q;
         end
      end else if (load) begin
         shadow_val_d = value_in;
         shadow_dp_d  = dp_in;
         pending_d    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q       <= '0;
         sel_q         <= 3'd0;
         active_val_q  <= 32'd0;
         active_dp_q   <= 8'd0;
         shadow_val_q  <= 32'd0;
         shadow_dp_q   <= 8'd0;
         pending_q     <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         presc_q       <= presc_d;
         sel_q         <= sel_d;
         active_val_q  <= active_val_d;
         active_dp_q   <= active_dp_d;
         shadow_val_q  <= shadow_val_d;
         shadow_dp_q   <= shadow_dp_d;
         pending_q     <= pending_d;
         frame_start_q <= frame_start_d;
      end
   end

   logic [4:0] nib_shift;
   logic [3:0] nib;
   logic       slot_blank;

`ifdef LEADING_ZERO_BLANK_EN
   logic [7:0] zero_upto;
   logic       zero_acc;
   logic       lz_blank;

   // zero_upto[k]: nibbles 0..k (leftmost first) are all zero
   always_comb begin
      zero_acc  = 1'b1;
      zero_upto = 8'd0;
      for (int i = 0; i < 8; i++) begin
         zero_acc     = zero_acc && (active_val_q[31-4*i -: 4] == 4'h0);
         zero_upto[i] = zero_acc;
      end
      lz_blank = (sel_q != 3'd7) && zero_upto[sel_q];
   end
`endif

   // Output decode from registered state only
   always_comb begin
      nib_shift  = 5'd28 - {sel_q, 2'b00};
      nib        = 4'(active_val_q >> nib_shift);
      slot_blank = (32'(presc_q) < BLANK_CYCLES);
      seg_out    = hex7(nib);
      dp_out     = ~active_dp_q[3'd7 - sel_q];
`ifdef LEADING_ZERO_BLANK_EN
      if (lz_blank) seg_out = 7'h7F;
`endif
      if (slot_blank) begin
         seg_out = 7'h7F;
         dp_out  = 1'b1;
      end
   end

   assign digit_sel   = sel_q;
   assign frame_start = frame_start_q;
   assign pending     = pending_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller (REFRESH_DIV=4, BLANK_CYCLES=1) with a per-cycle scoreboard.
module tb_display_scan_controller;

   localparam int unsigned DIV   = 4;
   localparam int unsigned BLANK = 1;

   typedef struct packed {
      logic [2:0] sel;
      logic [6:0] seg;
      logic       dp;
      logic       fs;
      logic       pend;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        load;
   logic [31:0] value_in;
   logic [7:0]  dp_in;
   logic [2:0]  digit_sel;
   logic [6:0]  seg_out;
   logic        dp_out;
   logic        frame_start;
   logic        pending;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic seen_one = 1'b0;

   exp_t sb_q[$];

   // Reference model state
   int          m_presc;
   logic [2:0]  m_sel;
   logic [31:0] m_act, m_sh;
   logic [7:0]  m_actdp, m_shdp;
   logic        m_pend, m_fs;

   logic [6:0] hex_tab [16];

   display_scan_controller #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
      .clk(clk), .rst(rst), .load(load), .value_in(value_in), .dp_in(dp_in),
      .digit_sel(digit_sel), .seg_out(seg_out), .dp_out(dp_out),
      .frame_start(frame_start), .pending(pending)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void model_update(input logic r, input logic ld, input logic [31:0] v,
                                        input logic [7:0] d);
      logic w;
      if (r) begin
         m_presc = 0; m_sel = 3'd0; m_act = 32'd0; m_sh = 32'd0;
         m_actdp = 8'd0; m_shdp = 8'd0; m_pend = 1'b0; m_fs = 1'b0;
         return;
      end
      w = (m_presc == int'(DIV) - 1) && (m_sel == 3'd7);
      m_fs = w;
      if (w) begin
         if (ld) begin
            m_act = v; m_actdp = d; m_sh = v; m_shdp = d;
         end else if (m_pend) begin
            m_act = m_sh; m_actdp = m_shdp;
         end
         m_pend = 1'b0;
      end else if (ld) begin
         m_sh = v; m_shdp = d; m_pend = 1'b1;
      end
      if (m_presc == int'(DIV) - 1) begin
         m_presc = 0;
         m_sel   = m_sel + 3'd1;
      end else begin
         m_presc = m_presc + 1;
      end
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      logic [31:0] upper;
      int k;
      k       = int'(m_sel);
      upper   = m_act >> (28 - 4 * k);
      e.sel   = m_sel;
      e.fs    = m_fs;
      e.pend  = m_pend;
      e.seg   = hex_tab[upper[3:0]];
      e.dp    = ~m_actdp[7 - k];
`ifdef LEADING_ZERO_BLANK_EN
      if (k < 7 && upper == 32'd0) e.seg = 7'h7F;
`endif
      if (m_presc < int'(BLANK)) begin
         e.seg = 7'h7F;
         e.dp  = 1'b1;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // One clock: drive inputs, update model at the edge, compare #1 later
   task automatic step(input logic r, input logic ld, input logic [31:0] v, input logic [7:0] d);
      exp_t e;
      exp_t got;
      rst = r; load = ld; value_in = v; dp_in = d;
      @(posedge clk);
      model_update(r, ld, v, d);
      sb_q.push_back(model_out());
      #1;
      cyc++;
      got = {digit_sel, seg_out, dp_out, frame_start, pending};
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $error("FAIL sb_empty: observed %0d entries expected 1 at cycle %0d", sb_q.size(), cyc);
      end else begin
         e = sb_q.pop_front();
         assert (got === e) else begin
            errors++;
            $error("FAIL sb_cycle%0d: observed %0h expected %0h", cyc, got, e);
         end
      end
      if (cyc >= 64 && cyc <= 95 && seg_out == 7'b1111001) seen_one = 1'b1;
      rst = 1'b0; load = 1'b0;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) step(1'b0, 1'b0, 32'd0, 8'd0);
   endtask

   initial begin
      hex_tab[0]  = 7'b1000000; hex_tab[1]  = 7'b1111001; hex_tab[2]  = 7'b0100100;
      hex_tab[3]  = 7'b0110000; hex_tab[4]  = 7'b0011001; hex_tab[5]  = 7'b0010010;
      hex_tab[6]  = 7'b0000010; hex_tab[7]  = 7'b1111000; hex_tab[8]  = 7'b0000000;
      hex_tab[9]  = 7'b0010000; hex_tab[10] = 7'b0001000; hex_tab[11] = 7'b0000011;
      hex_tab[12] = 7'b1000110; hex_tab[13] = 7'b0100001; hex_tab[14] = 7'b0000110;
      hex_tab[15] = 7'b0001110;
      rst = 1'b1; load = 1'b0; value_in = 32'd0; dp_in = 8'd0;
      model_update(1'b1, 1'b0, 32'd0, 8'd0);

      repeat (3) step(1'b1, 1'b0, 32'd0, 8'd0);
      cyc = 0;
      chk("rst_sel", 32'(digit_sel), 32'd0);
      chk("rst_seg", 32'(seg_out), 32'h7F);
      chk("rst_dp", 32'(dp_out), 32'd1);
      chk("rst_pend", 32'(pending), 32'd0);
      chk("rst_fs", 32'(frame_start), 32'd0);

      run_to(1);  chk("c1_seg0", 32'(seg_out), 32'b1000000);
      run_to(3);  chk("c3_seg0", 32'(seg_out), 32'b1000000);
      run_to(4);  chk("c4_sel1", 32'(digit_sel), 32'd1);
                  chk("c4_blank", 32'(seg_out), 32'h7F);

      run_to(10); step(1'b0, 1'b1, 32'h0123_4567, 8'h01);
      chk("load_pend", 32'(pending), 32'd1);
      run_to(29); chk("no_tear", 32'(seg_out), 32'b1000000);
      run_to(31); chk("pre_wrap_fs", 32'(frame_start), 32'd0);
      run_to(32); chk("fs_32", 32'(frame_start), 32'd1);
                  chk("commit_pend", 32'(pending), 32'd0);
      run_to(33); chk("f1_sel0", 32'(seg_out), 32'b1000000);
                  chk("f1_fs_drop", 32'(frame_start), 32'd0);
      run_to(37); chk("f1_sel1", 32'(seg_out), 32'b1111001);

      run_to(40); step(1'b0, 1'b1, 32'h1111_1111, 8'h00);
      run_to(50); step(1'b0, 1'b1, 32'h2222_2222, 8'h00);
      chk("double_pend", 32'(pending), 32'd1);
      run_to(61); chk("f1_sel7", 32'(seg_out), 32'b1111000);
                  chk("f1_sel7_dp", 32'(dp_out), 32'd0);
      run_to(64); chk("fs_64", 32'(frame_start), 32'd1);
      run_to(65); chk("f2_sel0_two", 32'(seg_out), 32'b0100100);
      run_to(89); chk("f2_sel6_two", 32'(seg_out), 32'b0100100);

      run_to(95); step(1'b0, 1'b1, 32'hFFFF_FFFF, 8'hFF);
      chk("wrap_load_pend", 32'(pending), 32'd0);
      chk("fs_96", 32'(frame_start), 32'd1);
      chk("no_ones_seen", 32'(seen_one), 32'd0);
      run_to(97); chk("wrap_load_F", 32'(seg_out), 32'b0001110);
                  chk("wrap_load_dp", 32'(dp_out), 32'd0);
                  chk("wrap_load_pend2", 32'(pending), 32'd0);

      run_to(100); step(1'b0, 1'b1, 32'h89AB_CDEF, 8'h00);
      chk("mid_pend", 32'(pending), 32'd1);
      run_to(116); chk("mid_sel5", 32'(digit_sel), 32'd5);
      step(1'b1, 1'b0, 32'd0, 8'd0);
      chk("mrst_sel", 32'(digit_sel), 32'd0);
      chk("mrst_pend", 32'(pending), 32'd0);
      chk("mrst_seg", 32'(seg_out), 32'h7F);
      cyc = 0;
      run_to(1); chk("mrst_active0", 32'(seg_out), 32'b1000000);

      run_to(2); step(1'b0, 1'b1, 32'h0000_00A0, 8'h00);
      run_to(32); chk("fs_after_rst", 32'(frame_start), 32'd1);
`ifdef LEADING_ZERO_BLANK_EN
      run_to(33); chk("lz_sel0", 32'(seg_out), 32'h7F);
      run_to(53); chk("lz_sel5", 32'(seg_out), 32'h7F);
`else
      run_to(33); chk("nolz_sel0", 32'(seg_out), 32'b1000000);
      run_to(53); chk("nolz_sel5", 32'(seg_out), 32'b1000000);
`endif
      run_to(57); chk("sel6_A", 32'(seg_out), 32'b0001000);
      run_to(61); chk("sel7_0", 32'(seg_out), 32'b1000000);
      run_to(64); chk("fs_64_again", 32'(frame_start), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
